// File: rtl/spine_pkg.sv
// spine_pkg
// Shared definitions for the DMX-over-spine transmitter slice.
//   spine_state_t         : framer state encoding
//   DMX_CLKS_PER_BIT_12M  : clocks per DMX bit at 12 MHz (250 kbaud)
//   DMX_BREAK_BITS        : BREAK length in bit times (88 us)
//   DMX_MAB_BITS          : mark-after-break length in bit times
//   DMX_STOP_BITS         : stop bits per slot (8N2)
//   PIN_IDLE              : level of every active-low output pin when inactive
package spine_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BREAK = 3'd1,
      ST_MAB   = 3'd2,
      ST_START = 3'd3,
      ST_DATA  = 3'd4,
      ST_STOP  = 3'd5
   } spine_state_t;

   localparam int DMX_CLKS_PER_BIT_12M = 48;
   localparam int DMX_BREAK_BITS       = 22;
   localparam int DMX_MAB_BITS         = 3;
   localparam int DMX_STOP_BITS        = 2;

   localparam logic PIN_IDLE = 1'b1;

endpackage

// File: rtl/spine_gate_pwm.sv
// spine_gate_pwm
// Alternating power-gate modulator. A free-running counter of 2^GATE_W clocks
// defines one gate period; the two gates take turns, one period each. The
// requested duty is only picked up at the period wrap so a period is never
// cut short, and the last DEADTIME clocks of every period are forced off so
// the two gates can never overlap.
// Ports:
//   CLK12      in   system clock
//   RST        in   synchronous reset, active-high
//   enable     in   run enable; low forces both gates off, counter holds
//   gate_duty  in   requested on-time in clocks per period
//   DMX_GATE1  out  gate A, active-low (registered)
//   DMX_GATE2  out  gate B, active-low (registered)
module spine_gate_pwm
   import spine_pkg::*;
#(
   parameter int GATE_W   = 7,
   parameter int DEADTIME = 4
)(
   input  logic              CLK12,
   input  logic              RST,
   input  logic              enable,
   input  logic [GATE_W-1:0] gate_duty,
   output logic              DMX_GATE1,
   output logic              DMX_GATE2
);

   localparam int              ON_LIMIT_I = (1 << GATE_W) - DEADTIME;
   localparam logic [GATE_W:0] ON_LIMIT   = ON_LIMIT_I[GATE_W:0];

   logic [GATE_W-1:0] r_cnt;
   logic [GATE_W-1:0] r_dutyQ;
   logic              r_phase;
   logic              r_gate1;
   logic              r_gate2;

   logic [GATE_W-1:0] w_nCnt;
   logic [GATE_W-1:0] w_nDuty;
   logic              w_nPhase;
   logic              w_on;

   // Next counter/phase/duty. The gate drive is derived from these next
   // values so the registered pins line up with the registered counter.
   always_comb begin
      w_nCnt   = r_cnt;
      w_nPhase = r_phase;
      w_nDuty  = r_dutyQ;
      if (enable) begin
         w_nCnt = r_cnt + 1'b1;
         if (r_cnt == '1) begin
            w_nPhase = !r_phase;
            w_nDuty  = gate_duty;
         end
      end
      w_on = enable && (w_nCnt < w_nDuty) && ({1'b0, w_nCnt} < ON_LIMIT);
   end

   // Period state and registered, mutually exclusive active-low gate pins.
   always_ff @(posedge CLK12) begin
      if (RST) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_dutyQ <= '0;
         r_gate1 <= PIN_IDLE;
         r_gate2 <= PIN_IDLE;
      end else begin
         r_cnt   <= w_nCnt;
         r_phase <= w_nPhase;
         r_dutyQ <= w_nDuty;
         r_gate1 <= !(w_on && w_nPhase);
         r_gate2 <= !(w_on && !w_nPhase);
      end
   end

   assign DMX_GATE1 = r_gate1;
   assign DMX_GATE2 = r_gate2;

endmodule

// File: rtl/spine_tx.sv
// spine_tx
// DMX-over-spine transmitter. Frames a byte stream into DMX packets
// (BREAK, MAB, then 8N2 slots) and drives the data pair with a free-running
// carrier whenever the line is at mark; the line at space leaves both legs
// off. The gate modulator lives in spine_gate_pwm.
// Optional build macro SPINE_TX_SLOTCOUNT_EN adds the slot_count output.
// Ports:
//   CLK12       in   system clock
//   RST         in   synchronous reset, active-high
//   enable      in   global run enable
//   gate_duty   in   requested gate on-time, clocks per period
//   in_data     in   slot byte
//   in_valid    in   byte available
//   in_last     in   marks in_data as the final slot of the frame
//   in_ready    out  byte accepted when in_valid && in_ready
//   busy        out  frame in progress
//   DMX_GATE1/2 out  power gates, active-low
//   DMX_TX1/2   out  data pair legs, active-low
//   slot_count  out  bytes accepted in the current/last frame (macro only)
module spine_tx
   import spine_pkg::*;
#(
   parameter int CLKS_PER_BIT = DMX_CLKS_PER_BIT_12M,
   parameter int BREAK_BITS   = DMX_BREAK_BITS,
   parameter int MAB_BITS     = DMX_MAB_BITS,
   parameter int CARRIER_DIV  = 1,
   parameter int GATE_W       = 7,
   parameter int DEADTIME     = 4
)(
   input  logic              CLK12,
   input  logic              RST,
   input  logic              enable,
   input  logic [GATE_W-1:0] gate_duty,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic              busy,
   output logic              DMX_GATE1,
   output logic              DMX_GATE2,
   output logic              DMX_TX1,
   output logic              DMX_TX2
`ifdef SPINE_TX_SLOTCOUNT_EN
   ,
   output logic [9:0]        slot_count
`endif
);

   localparam int BREAK_LEN = BREAK_BITS * CLKS_PER_BIT;
   localparam int MAB_LEN   = MAB_BITS * CLKS_PER_BIT;
   localparam int STOP_LEN  = DMX_STOP_BITS * CLKS_PER_BIT;
   localparam int MAX_A     = (BREAK_LEN > MAB_LEN) ? BREAK_LEN : MAB_LEN;
   localparam int MAX_LEN   = (MAX_A > STOP_LEN) ? MAX_A : STOP_LEN;
   localparam int CNT_W     = $clog2(MAX_LEN + 1);
   localparam int CAR_W     = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

   localparam logic [CNT_W-1:0] BREAK_END = CNT_W'(BREAK_LEN - 1);
   localparam logic [CNT_W-1:0] MAB_END   = CNT_W'(MAB_LEN - 1);
   localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_END  = CNT_W'(STOP_LEN - 1);
   localparam logic [CAR_W-1:0] CAR_END   = CAR_W'(CARRIER_DIV - 1);

   spine_state_t     r_state;
   spine_state_t     w_nState;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nCnt;
   logic [2:0]       r_bitIdx;
   logic [2:0]       w_nBitIdx;
   logic [7:0]       r_shift;
   logic [7:0]       w_nShift;
   logic             r_last;
   logic             w_nLast;
   logic             r_hold;
   logic             w_nHold;
   logic             r_busy;
   logic             w_nBusy;
   logic             r_ready;
   logic             w_nReady;
   logic             w_nLine;
   logic             w_accept;
   logic [CAR_W-1:0] r_carCnt;
   logic [CAR_W-1:0] w_nCarCnt;
   logic             r_carrier;
   logic             w_nCarrier;
   logic             r_tx1;
   logic             r_tx2;

   assign w_accept = in_valid && r_ready;

   spine_gate_pwm #(
      .GATE_W   (GATE_W),
      .DEADTIME (DEADTIME)
   ) u_gate (
      .CLK12     (CLK12),
      .RST       (RST),
      .enable    (enable),
      .gate_duty (gate_duty),
      .DMX_GATE1 (DMX_GATE1),
      .DMX_GATE2 (DMX_GATE2)
   );

   // Carrier divider: free-running, independent of enable and the framer.
   always_comb begin
      w_nCarCnt  = r_carCnt + 1'b1;
      w_nCarrier = r_carrier;
      if (r_carCnt == CAR_END) begin
         w_nCarCnt  = '0;
         w_nCarrier = !r_carrier;
      end
   end

   // Framer next-state logic. The end of STOP is the slot boundary: a byte
   // accepted there starts the next slot with no gap; with nothing offered
   // the framer parks in STOP (hold-mark) until a byte arrives or enable
   // drops. An accepted handshake always wins over closing the frame so a
   // byte the source has handed over is never lost.
   always_comb begin
      w_nState  = r_state;
      w_nCnt    = r_cnt + 1'b1;
      w_nBitIdx = r_bitIdx;
      w_nShift  = r_shift;
      w_nLast   = r_last;
      w_nHold   = r_hold;
      w_nBusy   = r_busy;
      case (r_state)
         ST_IDLE: begin
            w_nCnt = '0;
            if (w_accept) begin
               w_nState = ST_BREAK;
               w_nShift = in_data;
               w_nLast  = in_last;
               w_nBusy  = 1'b1;
            end
         end
         ST_BREAK: begin
            if (r_cnt == BREAK_END) begin
               w_nState = ST_MAB;
               w_nCnt   = '0;
            end
         end
         ST_MAB: begin
            if (r_cnt == MAB_END) begin
               w_nState = ST_START;
               w_nCnt   = '0;
            end
         end
         ST_START: begin
            if (r_cnt == BIT_END) begin
               w_nState  = ST_DATA;
               w_nCnt    = '0;
               w_nBitIdx = 3'd0;
            end
         end
         ST_DATA: begin
            if (r_cnt == BIT_END) begin
               w_nCnt   = '0;
               w_nShift = {1'b0, r_shift[7:1]};
               if (r_bitIdx == 3'd7) begin
                  w_nState = ST_STOP;
               end else begin
                  w_nBitIdx = r_bitIdx + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (r_hold || (r_cnt == STOP_END)) begin
               if (w_accept) begin
                  w_nState = ST_START;
                  w_nCnt   = '0;
                  w_nShift = in_data;
                  w_nLast  = in_last;
                  w_nHold  = 1'b0;
               end else if (r_last || !enable) begin
                  w_nState = ST_IDLE;
                  w_nCnt   = '0;
                  w_nHold  = 1'b0;
                  w_nBusy  = 1'b0;
               end else begin
                  w_nCnt  = r_cnt;
                  w_nHold = 1'b1;
               end
            end
         end
         default: begin
            w_nState = ST_IDLE;
            w_nCnt   = '0;
            w_nHold  = 1'b0;
            w_nBusy  = 1'b0;
         end
      endcase
   end

   // Handshake and line level for the coming cycle, derived from the next
   // state so the registered pins match the registered state exactly.
   always_comb begin
      w_nReady = 1'b0;
      w_nLine  = 1'b1;
      case (w_nState)
         ST_IDLE: begin
            w_nReady = enable;
            w_nLine  = enable;
         end
         ST_BREAK: w_nLine = 1'b0;
         ST_MAB:   w_nLine = 1'b1;
         ST_START: w_nLine = 1'b0;
         ST_DATA:  w_nLine = w_nShift[0];
         ST_STOP: begin
            w_nLine  = 1'b1;
            w_nReady = enable && !w_nLast && (w_nHold || (w_nCnt == STOP_END));
         end
         default: begin
            w_nReady = 1'b0;
            w_nLine  = 1'b0;
         end
      endcase
   end

   // Framer, carrier and registered data-pair drive.
   always_ff @(posedge CLK12) begin
      if (RST) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_bitIdx  <= 3'd0;
         r_shift   <= 8'd0;
         r_last    <= 1'b0;
         r_hold    <= 1'b0;
         r_busy    <= 1'b0;
         r_ready   <= 1'b0;
         r_carCnt  <= '0;
         r_carrier <= 1'b0;
         r_tx1     <= PIN_IDLE;
         r_tx2     <= PIN_IDLE;
      end else begin
         r_state   <= w_nState;
         r_cnt     <= w_nCnt;
         r_bitIdx  <= w_nBitIdx;
         r_shift   <= w_nShift;
         r_last    <= w_nLast;
         r_hold    <= w_nHold;
         r_busy    <= w_nBusy;
         r_ready   <= w_nReady;
         r_carCnt  <= w_nCarCnt;
         r_carrier <= w_nCarrier;
         r_tx1     <= !(w_nLine && w_nCarrier);
         r_tx2     <= !(w_nLine && !w_nCarrier);
      end
   end

   assign in_ready = r_ready;
   assign busy     = r_busy;
   assign DMX_TX1  = r_tx1;
   assign DMX_TX2  = r_tx2;

`ifdef SPINE_TX_SLOTCOUNT_EN
   logic [9:0] r_slotCount;

   // Slots of the current frame, start code included; a new frame restarts
   // the count at its first byte and the count survives frame close.
   always_ff @(posedge CLK12) begin
      if (RST) begin
         r_slotCount <= 10'd0;
      end else if (w_accept) begin
         if (r_state == ST_IDLE) begin
            r_slotCount <= 10'd1;
         end else if (r_slotCount != 10'h3FF) begin
            r_slotCount <= r_slotCount + 10'd1;
         end
      end
   end

   assign slot_count = r_slotCount;
`endif

endmodule

// File: tb/tb_spine_tx.sv
// tb_spine_tx
// Self-checking bench for spine_tx with default parameters. Frames are
// checked cycle by cycle against an expected line/handshake timeline built
// from the DMX frame rules (BREAK, MAB, 8N2 slots, hold-mark gaps).
module tb_spine_tx;

   localparam int CPB = 48;
   localparam int BRK = 22 * CPB;
   localparam int MAB = 3 * CPB;
   localparam int GPERIOD = 128;
   localparam int GLIMIT = 124;

   typedef struct packed {
      logic line;
      logic ready;
      logic busy;
   } exp_t;

   logic       CLK12 = 1'b0;
   logic       RST;
   logic       enable;
   logic [6:0] gate_duty;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic       busy;
   logic       DMX_GATE1;
   logic       DMX_GATE2;
   logic       DMX_TX1;
   logic       DMX_TX2;
`ifdef SPINE_TX_SLOTCOUNT_EN
   logic [9:0] slot_count;
`endif

   int total = 0;
   int bad = 0;

   logic [7:0] fBytes[8];
   int         fGap[8];
   int         fN;
   int         fDisable;
   int         acceptCycle[8];
   exp_t       expQ[$];

   spine_tx dut (
      .CLK12     (CLK12),
      .RST       (RST),
      .enable    (enable),
      .gate_duty (gate_duty),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .busy      (busy),
      .DMX_GATE1 (DMX_GATE1),
      .DMX_GATE2 (DMX_GATE2),
      .DMX_TX1   (DMX_TX1),
      .DMX_TX2   (DMX_TX2)
`ifdef SPINE_TX_SLOTCOUNT_EN
      ,
      .slot_count(slot_count)
`endif
   );

   always #5 CLK12 = ~CLK12;

   task automatic tick();
      @(posedge CLK12);
      #1;
   endtask

   task automatic pushN(input int n, input logic l, input logic r, input logic b);
      exp_t e;
      e.line  = l;
      e.ready = r;
      e.busy  = b;
      for (int i = 0; i < n; i++) expQ.push_back(e);
   endtask

   // Expected per-cycle timeline; cycle 0 is the first cycle after the
   // first byte is accepted.
   task automatic buildModel(output int nSlots, output logic endEn);
      int   c;
      logic rdy;
      expQ.delete();
      nSlots = 0;
      endEn  = 1'b1;
      for (int i = 0; i < 8; i++) acceptCycle[i] = 1 << 30;
      pushN(BRK, 1'b0, 1'b0, 1'b1);
      pushN(MAB, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < fN; k++) begin
         pushN(CPB, 1'b0, 1'b0, 1'b1);
         for (int b = 0; b < 8; b++) pushN(CPB, fBytes[k][b], 1'b0, 1'b1);
         pushN(2 * CPB - 1, 1'b1, 1'b0, 1'b1);
         c = expQ.size();
         rdy = (k != fN - 1) && !(fDisable >= 0 && fDisable <= c - 1);
         pushN(1, 1'b1, rdy, 1'b1);
         nSlots++;
         if (fDisable >= 0 && fDisable <= c) endEn = 1'b0;
         if (k == fN - 1 || !endEn) break;
         pushN(fGap[k + 1], 1'b1, 1'b1, 1'b1);
         acceptCycle[k + 1] = expQ.size() - 1;
      end
      pushN(1, endEn, endEn, 1'b0);
   endtask

   task automatic runFrame(input string name);
      int   nSlots, accepted, c;
      int   lineBad, readyBad, busyBad, togBad, gateBad, firstBad;
      logic endEn, mark, prevMark, prevTx1, hs;
      logic [1:0] tx;
      exp_t e;
      buildModel(nSlots, endEn);
      lineBad = 0; readyBad = 0; busyBad = 0; togBad = 0; gateBad = 0;
      firstBad = -1; prevMark = 1'b0; prevTx1 = 1'b1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL %s.preReady in_ready=%b need 1", name, in_ready);
      end
      in_valid = 1'b1;
      in_data  = fBytes[0];
      in_last  = (fN == 1);
      hs = in_valid && in_ready;
      tick();
      accepted = hs ? 1 : 0;
      for (c = 0; c < expQ.size(); c++) begin
         e  = expQ[c];
         tx = {DMX_TX1, DMX_TX2};
         mark = (tx == 2'b01) || (tx == 2'b10);
         if (e.line ? !mark : (tx !== 2'b11)) begin
            lineBad++;
            if (firstBad < 0) firstBad = c;
         end
         if (in_ready !== e.ready) begin
            readyBad++;
            if (firstBad < 0) firstBad = c;
         end
         if (busy !== e.busy) begin
            busyBad++;
            if (firstBad < 0) firstBad = c;
         end
         if (mark && prevMark && (DMX_TX1 === prevTx1)) togBad++;
         if (DMX_GATE1 === 1'b0 && DMX_GATE2 === 1'b0) gateBad++;
         if (fDisable >= 0 && c > fDisable && (DMX_GATE1 !== 1'b1 || DMX_GATE2 !== 1'b1)) gateBad++;
         prevMark = mark;
         prevTx1  = DMX_TX1;
         if (fDisable >= 0 && c >= fDisable) enable = 1'b0;
         if (accepted < fN && (fGap[accepted] == 0 || c >= acceptCycle[accepted])) begin
            in_valid = 1'b1;
            in_data  = fBytes[accepted];
            in_last  = (accepted == fN - 1);
         end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
         end
         hs = in_valid && in_ready;
         tick();
         if (hs) accepted++;
      end
      in_valid = 1'b0;
      total += 6;
      if (lineBad != 0) begin
         bad++;
         $display("[TB] FAIL %s.line badCycles=%0d need 0 (first bad cycle %0d)", name, lineBad, firstBad);
      end
      if (readyBad != 0) begin
         bad++;
         $display("[TB] FAIL %s.ready badCycles=%0d need 0 (first bad cycle %0d)", name, readyBad, firstBad);
      end
      if (busyBad != 0) begin
         bad++;
         $display("[TB] FAIL %s.busy badCycles=%0d need 0 (first bad cycle %0d)", name, busyBad, firstBad);
      end
      if (togBad != 0) begin
         bad++;
         $display("[TB] FAIL %s.carrier stuckCycles=%0d need 0", name, togBad);
      end
      if (gateBad != 0) begin
         bad++;
         $display("[TB] FAIL %s.gates badCycles=%0d need 0", name, gateBad);
      end
      if (accepted != nSlots) begin
         bad++;
         $display("[TB] FAIL %s.accepted got=%0d need %0d", name, accepted, nSlots);
      end
`ifdef SPINE_TX_SLOTCOUNT_EN
      total++;
      if (slot_count !== 10'(nSlots)) begin
         bad++;
         $display("[TB] FAIL %s.slotCount got=%0d need %0d", name, slot_count, nSlots);
      end
`endif
      enable = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset();
      RST = 1'b1; enable = 1'b0; gate_duty = 7'd0;
      in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0;
      repeat (3) tick();
      total++;
      if ({DMX_GATE1, DMX_GATE2, DMX_TX1, DMX_TX2, busy, in_ready} !== 6'b111100) begin
         bad++;
         $display("[TB] FAIL reset.pins got=%b need 111100", {DMX_GATE1, DMX_GATE2, DMX_TX1, DMX_TX2, busy, in_ready});
      end
      RST = 1'b0;
      tick();
      total++;
      if ({DMX_TX1, DMX_TX2, in_ready} !== 3'b110) begin
         bad++;
         $display("[TB] FAIL reset.disabledIdle got=%b need 110", {DMX_TX1, DMX_TX2, in_ready});
      end
      enable = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b1 || (DMX_TX1 ^ DMX_TX2) !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset.enabledIdle ready=%b tx=%b%b need ready 1 with carrier", in_ready, DMX_TX1, DMX_TX2);
      end
      repeat (20) tick();
      total++;
      if ({DMX_GATE1, DMX_GATE2} !== 2'b11) begin
         bad++;
         $display("[TB] FAIL reset.zeroDuty gates=%b need 11", {DMX_GATE1, DMX_GATE2});
      end
   endtask

   task automatic test_gate_duty(input int duty);
      int g1, g2, both, expOn;
      gate_duty = 7'(duty);
      expOn = (duty < GLIMIT) ? duty : GLIMIT;
      repeat (GPERIOD + 2) tick();
      g1 = 0; g2 = 0; both = 0;
      for (int i = 0; i < 2 * GPERIOD; i++) begin
         if (DMX_GATE1 === 1'b0) g1++;
         if (DMX_GATE2 === 1'b0) g2++;
         if (DMX_GATE1 === 1'b0 && DMX_GATE2 === 1'b0) both++;
         tick();
      end
      total += 3;
      if (g1 != expOn) begin
         bad++;
         $display("[TB] FAIL gate%0d.gate1Low got=%0d need %0d", duty, g1, expOn);
      end
      if (g2 != expOn) begin
         bad++;
         $display("[TB] FAIL gate%0d.gate2Low got=%0d need %0d", duty, g2, expOn);
      end
      if (both != 0) begin
         bad++;
         $display("[TB] FAIL gate%0d.overlap got=%0d need 0", duty, both);
      end
   endtask

   task automatic test_single_byte();
      fN = 1; fBytes[0] = 8'h00; fGap[0] = 0; fDisable = -1;
      runFrame("single");
   endtask

   task automatic test_back_to_back();
      fN = 3; fDisable = -1;
      fBytes[0] = 8'h00; fBytes[1] = 8'hA5; fBytes[2] = 8'hFF;
      for (int i = 0; i < 3; i++) fGap[i] = 0;
      runFrame("backToBack");
   endtask

   task automatic test_gap();
      fN = 3; fDisable = -1;
      fBytes[0] = 8'h00; fBytes[1] = 8'($urandom); fBytes[2] = 8'($urandom);
      fGap[0] = 0; fGap[1] = 300; fGap[2] = int'($urandom_range(1, 40));
      runFrame("gap");
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 3; f++) begin
         fN = (f == 0) ? 2 : int'($urandom_range(1, 4));
         fDisable = -1;
         for (int i = 0; i < fN; i++) begin
            fBytes[i] = 8'($urandom);
            fGap[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
         end
         fGap[0] = 0;
         runFrame($sformatf("random%0d", f));
      end
   endtask

   task automatic test_enable_fall();
      gate_duty = 7'd40;
      repeat (2 * GPERIOD) tick();
      fN = 2; fBytes[0] = 8'h00; fBytes[1] = 8'($urandom);
      fGap[0] = 0; fGap[1] = 0;
      fDisable = BRK + MAB + CPB + 3 * CPB + 10;
      runFrame("enableFall");
   endtask

   task automatic test_reset_mid_frame();
      in_valid = 1'b1; in_data = 8'($urandom); in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (BRK + MAB + 3 * CPB) tick();
      RST = 1'b1;
      tick();
      total++;
      if ({DMX_GATE1, DMX_GATE2, DMX_TX1, DMX_TX2, busy, in_ready} !== 6'b111100) begin
         bad++;
         $display("[TB] FAIL midReset.pins got=%b need 111100", {DMX_GATE1, DMX_GATE2, DMX_TX1, DMX_TX2, busy, in_ready});
      end
      RST = 1'b0; enable = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midReset.release ready=%b busy=%b need ready 1 busy 0", in_ready, busy);
      end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_gate_duty(22);
      test_gate_duty(127);
      test_gate_duty(int'($urandom_range(0, 127)));
      test_single_byte();
      test_back_to_back();
      test_gap();
      test_random_frames();
      test_enable_fall();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spine_tx.md
Name: spine_tx

Overview:
- Parametrised DMX-over-spine transmitter that replaces the fixed-pattern gate and data drive.
- Generates alternating power-gate modulation on DMX_GATE1/2 with programmable duty and enforced dead time.
- Serialises a byte stream into DMX frames (BREAK, MAB, slots 8N2) and drives DMX_TX1/2 with a carrier while the line is at mark.
- Sits between the packet source (UART bridge or pattern generator) and the top-level pins.

Parameters:
- CLKS_PER_BIT, 48, clock cycles per DMX bit (250 kbaud at 12 MHz); minimum 2.
- BREAK_BITS, 22, BREAK length in bit times (88 us).
- MAB_BITS, 3, mark-after-break length in bit times.
- CARRIER_DIV, 1, carrier half-period in clocks; minimum 1.
- GATE_W, 7, gate period counter width; period is 2^GATE_W clocks.
- DEADTIME, 4, clocks at the end of every gate period with both gates forced off.

Ports:
- CLK12  in  1  system clock
- RST  in  1  synchronous reset, active-high
- enable  in  1  global run enable
- gate_duty  in  GATE_W  requested gate on-time, in clocks per period
- in_data  in  8  slot byte
- in_valid  in  1  byte available
- in_last  in  1  qualifies in_data as the final slot of the frame
- in_ready  out  1  byte accepted when in_valid && in_ready
- busy  out  1  frame in progress
- DMX_GATE1  out  1  gate A, active-low
- DMX_GATE2  out  1  gate B, active-low
- DMX_TX1  out  1  data pair leg 1, active-low
- DMX_TX2  out  1  data pair leg 2, active-low

Behaviour:
- All outputs are registered. Reset and enable take effect on the first output edge after the rising clock edge that samples them; there is no combinational path from any input to any output.
- Reset: DMX_GATE1/2 = 1, DMX_TX1/2 = 1, in_ready = 0, busy = 0, FSM = IDLE, frame closed, all counters 0, carrier phase 0.
- Gate counter runs 0 .. 2^GATE_W-1 and wraps.
  - Phase bit toggles on wrap.
  - gate_duty is sampled on wrap; it is 0 after reset.
  - on = (cnt < duty_q) && (cnt < 2^GATE_W - DEADTIME).
  - GATE1 = !(on && phase); GATE2 = !(on && !phase).
  - duty_q = 0 gives both gates off. Duty at or above the dead-time limit is clipped.
  - The two gates are never low in the same cycle.
- enable = 0: gates go high on the next cycle, counter and phase hold, in_ready = 0.
- Carrier toggles every CARRIER_DIV clocks and free-runs.
- line_level is 1 at mark.
  - TX1 = !(line_level && carrier); TX2 = !(line_level && !carrier).
  - In IDLE with enable = 0, both TX lines are 1.
- FSM states: IDLE, BREAK, MAB, START, DATA, STOP.
- IDLE: line_level = 1 if enable, else TX is off. in_ready = enable.
  - On accept, latch the byte and in_last, set busy, then go to BREAK.
- BREAK: line 0 for BREAK_BITS*CLKS_PER_BIT cycles, then MAB.
- MAB: line 1 for MAB_BITS*CLKS_PER_BIT cycles, then START.
- START: line 0 for 1 bit. DATA: 8 bits, LSB first. STOP: line 1 for 2 bits.
- Last cycle of STOP:
  - If the latched last = 1, or enable = 0: close the frame, busy = 0, go to IDLE. The next accepted byte starts with BREAK.
  - Otherwise assert in_ready for that cycle. On accept, go straight to START with no gap.
  - If no byte is accepted, go to HOLD-MARK: a STOP sub-state with line 1, in_ready = 1 and busy = 1. It leaves to START on accept, or to IDLE (frame closed) if enable falls.
- Inter-slot idle time is unbounded.
- enable falling mid-slot: the current slot completes, then the block goes to IDLE.
- The latched byte and last flag are held until the slot finishes; input changes while not ready are ignored.

Optional Feature:
- Macro: SPINE_TX_SLOTCOUNT_EN.
- Defined: extra output slot_count[9:0].
  - Cleared on BREAK entry.
  - Incremented on each accepted byte, including the start code.
  - Saturates at 1023.
  - Holds its value after the frame closes.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- spine_pkg holds:
  - the FSM state enum;
  - DMX timing defaults (DMX_CLKS_PER_BIT_12M = 48, DMX_BREAK_BITS = 22, DMX_MAB_BITS = 3, DMX_STOP_BITS = 2);
  - the active-low output idle constant.
- Sub-module spine_gate_pwm (CLK12, RST, enable, gate_duty → DMX_GATE1/2) contains the gate counter, phase, duty sampling and dead time.
- spine_tx holds the framer, carrier and TX drive.

Test Plan:
- Reset mid-frame (RST pulsed in DATA) → next cycle all four pins = 1, busy = 0, in_ready = 0; after release with enable = 1, in_ready = 1.
- GATE_W = 7, DEADTIME = 4, gate_duty = 22 → each gate low 22 cycles per 128, alternating per period, never both low. gate_duty = 127 → on-time clipped to 124.
- Single byte 0x00 with in_last = 1 → BREAK 1056 cycles at TX off, MAB 144 cycles with carrier, start bit plus 8 zero bits (432 cycles off), 96 cycles carrier, then IDLE, busy = 0.
- Frame 0x00, 0xA5, 0xFF (last) with in_valid held → back-to-back slots with no gap; the 0xA5 bit pattern LSB first is 1,0,1,0,0,1,0,1 (observed as carrier presence); a single BREAK per frame.
- in_valid dropped for 300 cycles between slots → line stays at mark with busy = 1; the next byte starts with START, not BREAK.
- enable falling during the bit-3 DATA cycle → slot finishes through STOP, gates high immediately, FSM returns to IDLE. With SPINE_TX_SLOTCOUNT_EN defined, slot_count = 2 after a two-byte frame.
